// File: rtl/rect_raster_render.sv
// rect_raster_render
// Purpose: holds up to NUM_RECT rectangles in a shadow bank that control
// logic writes, publishes the shadow bank to an active bank only at a frame
// start, and tests the live scan position against the active bank. The hit
// flag and lowest-index hit are registered with a fixed 2-cycle latency.
// Ports:
//   pixel_clk, rst          : clock and synchronous active-high reset
//   wr_en/wr_idx/wr_x1..y2  : write one shadow slot (low corner inclusive,
//   wr_vis                    high corner exclusive) and its visible flag
//   wr_ready                : writes accepted while high (state OPEN)
//   commit_req              : arm a publish of the shadow bank
//   commit_pending          : a publish is armed and waiting for frame_start
//   frame_start             : pulse at scan position (0,0)
//   hcount, vcount          : current scan position
//   pix_on, pix_idx         : hit flag and lowest hit index, 2 cycles late
module rect_raster_render #(
  parameter int NUM_RECT = 8,
  parameter int IDX_W    = 3,
  parameter int COORD_W  = 11,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x1,
  input  logic [COORD_W-1:0] wr_y1,
  input  logic [COORD_W-1:0] wr_x2,
  input  logic [COORD_W-1:0] wr_y2,
  input  logic               wr_vis,
  output logic               wr_ready,
  input  logic               commit_req,
  output logic               commit_pending,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  output logic               pix_on,
  output logic [IDX_W-1:0]   pix_idx
);

  localparam logic [0:0] ST_OPEN    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0] state_q, state_d;

  logic [COORD_W-1:0] sh_x1_q [NUM_RECT];
  logic [COORD_W-1:0] sh_y1_q [NUM_RECT];
  logic [COORD_W-1:0] sh_x2_q [NUM_RECT];
  logic [COORD_W-1:0] sh_y2_q [NUM_RECT];
  logic [NUM_RECT-1:0] sh_vis_q;
  logic [COORD_W-1:0] sh_x1_d [NUM_RECT];
  logic [COORD_W-1:0] sh_y1_d [NUM_RECT];
  logic [COORD_W-1:0] sh_x2_d [NUM_RECT];
  logic [COORD_W-1:0] sh_y2_d [NUM_RECT];
  logic [NUM_RECT-1:0] sh_vis_d;

  logic [COORD_W-1:0] ac_x1_q [NUM_RECT];
  logic [COORD_W-1:0] ac_y1_q [NUM_RECT];
  logic [COORD_W-1:0] ac_x2_q [NUM_RECT];
  logic [COORD_W-1:0] ac_y2_q [NUM_RECT];
  logic [NUM_RECT-1:0] ac_vis_q;
  logic [COORD_W-1:0] ac_x1_d [NUM_RECT];
  logic [COORD_W-1:0] ac_y1_d [NUM_RECT];
  logic [COORD_W-1:0] ac_x2_d [NUM_RECT];
  logic [COORD_W-1:0] ac_y2_d [NUM_RECT];
  logic [NUM_RECT-1:0] ac_vis_d;

  logic                wr_accept_s;
  logic                commit_s;
  logic [NUM_RECT-1:0] hit_s;
  logic [NUM_RECT-1:0] hit_q;
  logic                pix_on_q;
  logic [IDX_W-1:0]    pix_idx_q;

  // Lowest set bit of the hit vector; 0 when nothing is set.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_RECT-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign wr_ready       = (state_q == ST_OPEN);
  assign commit_pending = (state_q == ST_PENDING);
  assign pix_on         = pix_on_q;
  assign pix_idx        = pix_idx_q;

  assign wr_accept_s = wr_en && (state_q == ST_OPEN);
  // A same-edge commit_req+frame_start in OPEN commits immediately.
  assign commit_s = frame_start &&
                    ((state_q == ST_PENDING) || ((state_q == ST_OPEN) && commit_req));

  // Next FSM state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN: begin
        if (commit_req && !frame_start) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_OPEN;
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          state_d = ST_OPEN;
        end else begin
          state_d = ST_PENDING;
        end
      end
      default: state_d = ST_OPEN;
    endcase
  end

  // Next shadow bank; the write is merged here so a same-edge commit sees it.
  always_comb begin
    sh_x1_d  = sh_x1_q;
    sh_y1_d  = sh_y1_q;
    sh_x2_d  = sh_x2_q;
    sh_y2_d  = sh_y2_q;
    sh_vis_d = sh_vis_q;
    if (wr_accept_s) begin
      sh_x1_d[wr_idx]  = wr_x1;
      sh_y1_d[wr_idx]  = wr_y1;
      sh_x2_d[wr_idx]  = wr_x2;
      sh_y2_d[wr_idx]  = wr_y2;
      sh_vis_d[wr_idx] = wr_vis;
    end else begin
      sh_vis_d = sh_vis_q;
    end
  end

  // Next active bank. The hit test uses this next value so a commit taken at
  // frame_start already applies to pixel (0,0) of that frame.
  always_comb begin
    ac_x1_d  = ac_x1_q;
    ac_y1_d  = ac_y1_q;
    ac_x2_d  = ac_x2_q;
    ac_y2_d  = ac_y2_q;
    ac_vis_d = ac_vis_q;
    if (commit_s) begin
      ac_x1_d  = sh_x1_d;
      ac_y1_d  = sh_y1_d;
      ac_x2_d  = sh_x2_d;
      ac_y2_d  = sh_y2_d;
      ac_vis_d = sh_vis_d;
    end else begin
      ac_vis_d = ac_vis_q;
    end
  end

  // Per-slot hit test; degenerate slots (x2<=x1 or y2<=y1) fail naturally.
  always_comb begin
    hit_s = '0;
    if ((hcount >= COORD_W'(H_ACTIVE)) || (vcount >= COORD_W'(V_ACTIVE))) begin
      hit_s = '0;
    end else begin
      for (int i = 0; i < NUM_RECT; i++) begin
        hit_s[i] = ac_vis_d[i] &&
                   (hcount >= ac_x1_d[i]) && (hcount < ac_x2_d[i]) &&
                   (vcount >= ac_y1_d[i]) && (vcount < ac_y2_d[i]);
      end
    end
  end

  // State, both banks and the two pipeline stages.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q   <= ST_OPEN;
      sh_vis_q  <= '0;
      ac_vis_q  <= '0;
      for (int i = 0; i < NUM_RECT; i++) begin
        sh_x1_q[i] <= '0;
        sh_y1_q[i] <= '0;
        sh_x2_q[i] <= '0;
        sh_y2_q[i] <= '0;
        ac_x1_q[i] <= '0;
        ac_y1_q[i] <= '0;
        ac_x2_q[i] <= '0;
        ac_y2_q[i] <= '0;
      end
      hit_q     <= '0;
      pix_on_q  <= 1'b0;
      pix_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      sh_x1_q   <= sh_x1_d;
      sh_y1_q   <= sh_y1_d;
      sh_x2_q   <= sh_x2_d;
      sh_y2_q   <= sh_y2_d;
      sh_vis_q  <= sh_vis_d;
      ac_x1_q   <= ac_x1_d;
      ac_y1_q   <= ac_y1_d;
      ac_x2_q   <= ac_x2_d;
      ac_y2_q   <= ac_y2_d;
      ac_vis_q  <= ac_vis_d;
      hit_q     <= hit_s;
      pix_on_q  <= |hit_q;
      pix_idx_q <= lowest_idx(hit_q);
    end
  end

endmodule

// File: tb/tb_rect_raster_render.sv
// tb_rect_raster_render
// Directed bench: one task per scenario, each comparing DUT outputs against
// hand-computed values. Inputs change on the falling edge, outputs are
// sampled on the falling edge after the rising edge that updates them.
module tb_rect_raster_render;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_idx = 3'd0;
  logic [10:0] wr_x1 = 11'd0;
  logic [10:0] wr_y1 = 11'd0;
  logic [10:0] wr_x2 = 11'd0;
  logic [10:0] wr_y2 = 11'd0;
  logic        wr_vis = 1'b0;
  logic        wr_ready;
  logic        commit_req = 1'b0;
  logic        commit_pending;
  logic        frame_start = 1'b0;
  logic [10:0] hcount = 11'd0;
  logic [10:0] vcount = 11'd0;
  logic        pix_on;
  logic [2:0]  pix_idx;

  int n_vec = 0;
  int n_err = 0;

  rect_raster_render dut (
    .pixel_clk      (pixel_clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_idx         (wr_idx),
    .wr_x1          (wr_x1),
    .wr_y1          (wr_y1),
    .wr_x2          (wr_x2),
    .wr_y2          (wr_y2),
    .wr_vis         (wr_vis),
    .wr_ready       (wr_ready),
    .commit_req     (commit_req),
    .commit_pending (commit_pending),
    .frame_start    (frame_start),
    .hcount         (hcount),
    .vcount         (vcount),
    .pix_on         (pix_on),
    .pix_idx        (pix_idx)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic step();
    @(posedge pixel_clk);
    @(negedge pixel_clk);
  endtask

  task automatic check_ctl(input string name, input logic exp_ready, input logic exp_pend);
    n_vec++;
    if (wr_ready !== exp_ready || commit_pending !== exp_pend) begin
      n_err++;
      $display("FAIL %s: wr_ready=%b commit_pending=%b, required %b %b",
               name, wr_ready, commit_pending, exp_ready, exp_pend);
    end
  endtask

  task automatic check_pix(input string name, input logic exp_on, input logic [2:0] exp_idx);
    n_vec++;
    if (pix_on !== exp_on || pix_idx !== exp_idx) begin
      n_err++;
      $display("FAIL %s: pix_on=%b pix_idx=%0d, required %b %0d",
               name, pix_on, pix_idx, exp_on, exp_idx);
    end
  endtask

  task automatic write_slot(input logic [2:0] idx, input int x1, input int y1,
                            input int x2, input int y2, input logic vis);
    wr_en  = 1'b1;
    wr_idx = idx;
    wr_x1  = 11'(x1);
    wr_y1  = 11'(y1);
    wr_x2  = 11'(x2);
    wr_y2  = 11'(y2);
    wr_vis = vis;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic frame_pulse();
    hcount      = 11'd0;
    vcount      = 11'd0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic arm_commit();
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
  endtask

  // Present (h,v) and check the output two rising edges later.
  task automatic probe(input string name, input int h, input int v,
                       input logic exp_on, input logic [2:0] exp_idx);
    hcount = 11'(h);
    vcount = 11'(v);
    step();
    step();
    check_pix(name, exp_on, exp_idx);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_pix("reset_pix", 1'b0, 3'd0);
    check_ctl("reset_ctl", 1'b1, 1'b0);
    // Strided idle scan of the visible area: nothing may ever hit.
    for (int v = 0; v < 480; v += 16) begin
      for (int h = 0; h < 640; h += 16) begin
        hcount = 11'(h);
        vcount = 11'(v);
        frame_start = (h == 0 && v == 0);
        step();
        n_vec++;
        if (pix_on !== 1'b0 || pix_idx !== 3'd0 || wr_ready !== 1'b1 || commit_pending !== 1'b0) begin
          n_err++;
          $display("FAIL idle_scan(%0d,%0d): pix_on=%b pix_idx=%0d ready=%b pend=%b, required 0 0 1 0",
                   h, v, pix_on, pix_idx, wr_ready, commit_pending);
        end
      end
    end
    frame_start = 1'b0;
  endtask

  task automatic test_basic();
    write_slot(3'd0, 100, 50, 102, 144, 1'b1);
    probe("pre_commit_100_50", 100, 50, 1'b0, 3'd0);
    arm_commit();
    check_ctl("armed_ctl", 1'b0, 1'b1);
    frame_pulse();
    check_ctl("taken_ctl", 1'b1, 1'b0);
    probe("hit_100_50", 100, 50, 1'b1, 3'd0);
    probe("hit_101_143", 101, 143, 1'b1, 3'd0);
    probe("miss_102_50", 102, 50, 1'b0, 3'd0);
    probe("miss_99_50", 99, 50, 1'b0, 3'd0);
    probe("miss_100_144", 100, 144, 1'b0, 3'd0);
  endtask

  task automatic test_pending();
    write_slot(3'd6, 300, 300, 310, 310, 1'b1);
    probe("shadow_only_305", 305, 305, 1'b0, 3'd0);
    frame_pulse();
    probe("no_commit_frame_305", 305, 305, 1'b0, 3'd0);
    arm_commit();
    write_slot(3'd1, 200, 200, 210, 210, 1'b1);
    check_ctl("pending_ctl", 1'b0, 1'b1);
    probe("pending_old_305", 305, 305, 1'b0, 3'd0);
    probe("pending_old_100_50", 100, 50, 1'b1, 3'd0);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    check_ctl("pending_recommit_ctl", 1'b0, 1'b1);
    frame_pulse();
    check_ctl("pending_taken_ctl", 1'b1, 1'b0);
    probe("new_305", 305, 305, 1'b1, 3'd6);
    probe("ignored_write_205", 205, 205, 1'b0, 3'd0);
  endtask

  task automatic test_overlap();
    write_slot(3'd2, 10, 10, 20, 20, 1'b1);
    write_slot(3'd5, 15, 15, 30, 30, 1'b1);
    arm_commit();
    frame_pulse();
    probe("overlap_16", 16, 16, 1'b1, 3'd2);
    probe("overlap_25", 25, 25, 1'b1, 3'd5);
    probe("overlap_12", 12, 12, 1'b1, 3'd2);
    probe("overlap_30", 30, 30, 1'b0, 3'd0);
  endtask

  task automatic test_degenerate_blank();
    write_slot(3'd3, 50, 50, 50, 60, 1'b1);
    write_slot(3'd4, 630, 0, 700, 10, 1'b1);
    write_slot(3'd7, 0, 470, 5, 500, 1'b1);
    arm_commit();
    frame_pulse();
    probe("degen_50_55", 50, 55, 1'b0, 3'd0);
    probe("degen_49_55", 49, 55, 1'b0, 3'd0);
    probe("edge_639", 639, 5, 1'b1, 3'd4);
    probe("blank_640", 640, 5, 1'b0, 3'd0);
    probe("blank_699", 699, 5, 1'b0, 3'd0);
    probe("vedge_479", 2, 479, 1'b1, 3'd7);
    probe("vblank_480", 2, 480, 1'b0, 3'd0);
  endtask

  task automatic test_same_cycle();
    // Write, commit and frame start on one edge; pixel (0,0) must see it.
    wr_en       = 1'b1;
    wr_idx      = 3'd1;
    wr_x1       = 11'd0;
    wr_y1       = 11'd0;
    wr_x2       = 11'd4;
    wr_y2       = 11'd4;
    wr_vis      = 1'b1;
    commit_req  = 1'b1;
    frame_start = 1'b1;
    hcount      = 11'd0;
    vcount      = 11'd0;
    step();
    wr_en       = 1'b0;
    commit_req  = 1'b0;
    frame_start = 1'b0;
    check_ctl("same_cycle_ctl", 1'b1, 1'b0);
    hcount = 11'd1;
    step();
    check_pix("same_cycle_pix_0_0", 1'b1, 3'd1);
    probe("same_cycle_3_3", 3, 3, 1'b1, 3'd1);
  endtask

  task automatic test_reset_pending();
    probe("pre_rst_2_2", 2, 2, 1'b1, 3'd1);
    arm_commit();
    check_ctl("pre_rst_ctl", 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_pix("rst_pix", 1'b0, 3'd0);
    check_ctl("rst_ctl", 1'b1, 1'b0);
    probe("rst_active_clear", 2, 2, 1'b0, 3'd0);
    arm_commit();
    frame_pulse();
    probe("rst_shadow_clear", 2, 2, 1'b0, 3'd0);
    probe("rst_shadow_clear_305", 305, 305, 1'b0, 3'd0);
  endtask

  initial begin
    @(negedge pixel_clk);
    test_reset();
    test_basic();
    test_pending();
    test_overlap();
    test_degenerate_blank();
    test_same_cycle();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rect_raster_render.md
Name: rect_raster_render

Overview:
- Downstream consumer of the rectangle-geometry blocks (vline and siblings), which output corner pairs (x1,y1)-(x2,y2).
- Holds up to NUM_RECT rectangles in a shadow bank written by control logic.
- Copies the shadow bank to an active bank only at frame start, so the display never tears.
- Compares the live VGA scan position against the active bank and emits a registered per-pixel hit flag and rectangle index to the colour mux.

Parameters:
- NUM_RECT, 8, number of rectangle slots (power of 2).
- IDX_W, 3, slot index width, equal to log2(NUM_RECT).
- COORD_W, 11, coordinate width; matches the 11-bit geometry outputs.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.

Ports:
- pixel_clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request for one shadow slot.
- wr_idx  in  IDX_W  target slot.
- wr_x1, wr_y1, wr_x2, wr_y2  in  COORD_W each  rectangle corners.
- wr_vis  in  1  slot-visible flag.
- wr_ready  out  1  writes are accepted while high.
- commit_req  in  1  single-cycle pulse: publish the shadow bank at the next frame start.
- commit_pending  out  1  a commit is armed and not yet taken.
- frame_start  in  1  single-cycle pulse at hcount=0, vcount=0 from the VGA timing block.
- hcount, vcount  in  COORD_W each  current scan position.
- pix_on  out  1  the scan position from 2 cycles earlier lies inside a visible rectangle.
- pix_idx  out  IDX_W  lowest-index rectangle hit; 0 when pix_on=0.

Behaviour:
- Reset (synchronous, while rst=1 at the pixel_clk edge):
  - all shadow and active vis bits and coordinates cleared to 0;
  - state OPEN; wr_ready=1; commit_pending=0;
  - pix_on=0, pix_idx=0; pipeline registers cleared.
  - Reset wins over every other input in the same cycle, including a mid-frame or mid-commit reset.
- State machine, 2 states:
  - OPEN: wr_ready=1, commit_pending=0.
    - wr_en=1 writes the slot at the clock edge.
    - commit_req=1 → PENDING.
    - commit_req=1 and frame_start=1 in the same cycle → commit that edge and stay OPEN.
  - PENDING: wr_ready=0, commit_pending=1.
    - wr_en is ignored; the shadow bank is unchanged.
    - frame_start=1 → active bank := shadow bank (all slots, one edge) → OPEN.
    - commit_req while PENDING has no effect.
- Same-edge write and commit (OPEN, wr_en=1, commit_req=1, frame_start=1): the write is applied to the shadow bank first, and the committed copy includes it.
- frame_start with no commit armed: the active bank is unchanged.
- Hit test per slot i, using the active bank:
  - hit_i = vis_i AND x1_i ≤ hcount < x2_i AND y1_i ≤ vcount < y2_i.
  - Low edge inclusive, high edge exclusive: vline default length=2 gives 2 columns, width=94 gives 94 rows.
  - Unsigned compares at COORD_W bits.
  - x2 ≤ x1 or y2 ≤ y1 → the slot never hits. No wrap-around interpretation.
- Blanking: hcount ≥ H_ACTIVE or vcount ≥ V_ACTIVE forces all hits to 0.
- Pipeline, latency exactly 2 cycles:
  - stage 1 registers the hit vector;
  - stage 2 registers pix_on = OR(hits) and pix_idx = lowest set index.
  - The output at edge t+2 corresponds to hcount/vcount sampled at edge t.
- Commit timing: a commit taken at the frame_start edge affects the hit tests of that same frame's pixel (0,0).
- Overlap: the lowest index wins pix_idx; pix_on=1.

Test Plan:
- Reset, then idle → pix_on=0, pix_idx=0, wr_ready=1, commit_pending=0 across a full 640x480 scan.
- Write slot 0 = (100,50)-(102,144), vis=1; commit_req; frame_start → after commit, scan (100,50) gives pix_on=1 and pix_idx=0 two cycles later. (101,143) hits; (102,50), (99,50) and (100,144) miss.
- commit_req mid-frame, then wr_en to slot 1 → write ignored, wr_ready=0, commit_pending=1. The old active image persists until the next frame_start, then the new image appears. Slot 1 keeps its prior value.
- Overlap: slot 2 = (10,10)-(20,20) and slot 5 = (15,15)-(30,30), both visible; scan (16,16) → pix_idx=2; scan (25,25) → pix_idx=5.
- Degenerate and blanking cases:
  - slot 3 = (50,50)-(50,60) never hits;
  - slot 4 = (630,0)-(700,10): hits at hcount=639 and is suppressed at hcount=640..699.
- Edge cases:
  - same-cycle wr_en, commit_req and frame_start → the written slot is visible in the same frame;
  - rst asserted while PENDING → state OPEN, both banks cleared, pix_on=0 on the next edge.
